// File: rtl/rs_issue_select.sv
// Issue-stage selector: picks one busy+ready RS entry per cycle and latches it into the IS/EX register.
// Optional macro RS_ISSUE_AGE_SELECT_EN enables oldest-first selection through an age matrix.
module rs_issue_select #(
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = $clog2(RS_SIZE),
  parameter int DATA_W   = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [RS_SIZE-1:0]              rs_busy,
  input  logic [RS_SIZE-1:0]              rs_ready,
  input  logic [RS_SIZE-1:0][DATA_W-1:0]  rs_packets,
  input  logic [RS_SIZE-1:0]              alloc_en,
  input  logic                            fu_stall,
  input  logic                            flush,
  output logic [RS_SIZE-1:0]              rs_clear,
  output logic                            is_valid,
  output logic [DATA_W-1:0]               is_packet,
  output logic [RS_IDX_W-1:0]             is_rs_idx
);

  logic [RS_SIZE-1:0]  eligible;
  logic [RS_SIZE-1:0]  cand;
  logic [RS_SIZE-1:0]  win_oh;
  logic [RS_IDX_W-1:0] win_idx;
  logic                have_win;
  logic                advance;

  logic                vld_p1;
  logic [DATA_W-1:0]   pkt_p1;
  logic [RS_IDX_W-1:0] idx_p1;

`ifdef RS_ISSUE_AGE_SELECT_EN
  // older[i][j] = 1 means entry i was allocated before entry j
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older;
  logic [RS_SIZE-1:0]              age_win;

  assign eligible = rs_busy & rs_ready & ~alloc_en;

  always_comb begin
    age_win = eligible;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (j != i && eligible[j] && !older[i][j]) age_win[i] = 1'b0;
      end
    end
  end

  // An inconsistent matrix (e.g. after reset or flush) falls back to lowest index
  assign cand = (|age_win) ? age_win : eligible;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      older <= '0;
    end else if (flush) begin
      older <= '0;
    end else begin
      for (int k = 0; k < RS_SIZE; k++) begin
        if (alloc_en[k]) begin
          for (int j = 0; j < RS_SIZE; j++) begin
            older[k][j] <= 1'b0;
            if (j != k) older[j][k] <= 1'b1;
          end
        end
      end
    end
  end
`else
  logic unused_alloc;

  assign unused_alloc = ^alloc_en;
  assign eligible     = rs_busy & rs_ready;
  assign cand         = eligible;
`endif

  // Lowest set bit of the candidate vector gives at most one winner
  assign win_oh   = cand & (~cand + RS_SIZE'(1));
  assign have_win = |cand;

  always_comb begin
    win_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = RS_IDX_W'(i);
    end
  end

  assign advance  = ~vld_p1 | ~fu_stall;
  assign rs_clear = (advance && !flush) ? win_oh : '0;

  // ---- IS/EX issue register (p1) ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      pkt_p1 <= '0;
      idx_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= have_win;
      if (have_win) begin
        pkt_p1 <= rs_packets[win_idx];
        idx_p1 <= win_idx;
      end
    end
  end

  assign is_valid  = vld_p1;
  assign is_packet = pkt_p1;
  assign is_rs_idx = idx_p1;

endmodule

// File: tb/tb_rs_issue_select.sv
// Table-driven bench for rs_issue_select; expectations follow RS_ISSUE_AGE_SELECT_EN when defined.
module tb_rs_issue_select;

  logic                 clock;
  logic                 reset;
  logic [7:0]           rs_busy;
  logic [7:0]           rs_ready;
  logic [7:0][31:0]     rs_packets;
  logic [7:0]           alloc_en;
  logic                 fu_stall;
  logic                 flush;
  logic [7:0]           rs_clear;
  logic                 is_valid;
  logic [31:0]          is_packet;
  logic [2:0]           is_rs_idx;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  busy;
    logic [7:0]  ready;
    logic [7:0]  alloc;
    logic        stall;
    logic        flsh;
    logic [7:0]  clr;
    logic        v;
    logic [2:0]  idx;
    logic [31:0] pkt;
  } vec_t;

  typedef struct {
    logic        v;
    logic [2:0]  idx;
    logic [31:0] pkt;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  rs_issue_select #(.RS_SIZE(8), .DATA_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .rs_busy    (rs_busy),
    .rs_ready   (rs_ready),
    .rs_packets (rs_packets),
    .alloc_en   (alloc_en),
    .fu_stall   (fu_stall),
    .flush      (flush),
    .rs_clear   (rs_clear),
    .is_valid   (is_valid),
    .is_packet  (is_packet),
    .is_rs_idx  (is_rs_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic [7:0] r, input logic [7:0] a,
                     input logic s, input logic f, input logic [7:0] c,
                     input logic v, input logic [2:0] i, input logic [31:0] p);
    vec_t t;
    t.busy = b; t.ready = r; t.alloc = a; t.stall = s; t.flsh = f;
    t.clr = c; t.v = v; t.idx = i; t.pkt = p;
    vecs.push_back(t);
  endtask

  task automatic idle_inputs();
    rs_busy = '0; rs_ready = '0; alloc_en = '0; fu_stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 8; i++) rs_packets[i] = 32'hABCDEF11 + 32'(i);

    // busy  ready alloc stl fl  clear v idx packet
    add(8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 32'h00000000);
    add(8'h00, 8'h00, 8'h20, 0, 0, 8'h00, 0, 0, 32'h00000000);
    add(8'h00, 8'h00, 8'h04, 0, 0, 8'h00, 0, 0, 32'h00000000);
    add(8'h00, 8'h00, 8'h80, 0, 0, 8'h00, 0, 0, 32'h00000000);
`ifdef RS_ISSUE_AGE_SELECT_EN
    add(8'hA4, 8'hA4, 8'h00, 0, 0, 8'h20, 1, 5, 32'hABCDEF16);
    add(8'h84, 8'h84, 8'h00, 0, 0, 8'h04, 1, 2, 32'hABCDEF13);
`else
    add(8'hA4, 8'hA4, 8'h00, 0, 0, 8'h04, 1, 2, 32'hABCDEF13);
    add(8'hA0, 8'hA0, 8'h00, 0, 0, 8'h20, 1, 5, 32'hABCDEF16);
`endif
    add(8'h80, 8'h80, 8'h00, 0, 0, 8'h80, 1, 7, 32'hABCDEF18);
    add(8'h08, 8'h08, 8'h00, 0, 0, 8'h08, 1, 3, 32'hABCDEF14);
    add(8'h10, 8'h10, 8'h00, 1, 0, 8'h00, 1, 3, 32'hABCDEF14);
    add(8'h10, 8'h10, 8'h00, 1, 0, 8'h00, 1, 3, 32'hABCDEF14);
    add(8'h10, 8'h10, 8'h00, 1, 0, 8'h00, 1, 3, 32'hABCDEF14);
    add(8'h10, 8'h10, 8'h00, 0, 0, 8'h10, 1, 4, 32'hABCDEF15);
    add(8'h00, 8'h00, 8'h02, 0, 0, 8'h00, 0, 4, 32'hABCDEF15);
    add(8'h02, 8'h00, 8'h40, 0, 0, 8'h00, 0, 4, 32'hABCDEF15);
    add(8'h42, 8'h40, 8'h00, 0, 0, 8'h40, 1, 6, 32'hABCDEF17);
    add(8'h02, 8'h02, 8'h00, 0, 0, 8'h02, 1, 1, 32'hABCDEF12);
    add(8'h08, 8'h08, 8'h01, 0, 1, 8'h00, 0, 1, 32'hABCDEF12);
    add(8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 32'hABCDEF12);
    add(8'h24, 8'h24, 8'h00, 0, 0, 8'h04, 1, 2, 32'hABCDEF13);
    add(8'h20, 8'h20, 8'h00, 0, 0, 8'h20, 1, 5, 32'hABCDEF16);
    add(8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 5, 32'hABCDEF16);
    add(8'h01, 8'h01, 8'h00, 1, 0, 8'h01, 1, 0, 32'hABCDEF11);
    add(8'h02, 8'h02, 8'h00, 1, 0, 8'h00, 1, 0, 32'hABCDEF11);
    add(8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 32'hABCDEF11);
`ifdef RS_ISSUE_AGE_SELECT_EN
    add(8'h08, 8'h08, 8'h08, 0, 0, 8'h00, 0, 0, 32'hABCDEF11);
    add(8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 32'hABCDEF11);
`else
    add(8'h08, 8'h08, 8'h08, 0, 0, 8'h08, 1, 3, 32'hABCDEF14);
    add(8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 3, 32'hABCDEF14);
`endif

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_valid",  32'(is_valid),  32'h0);
    chk("reset_packet", is_packet,      32'h0);
    chk("reset_idx",    32'(is_rs_idx), 32'h0);
    chk("reset_clear",  32'(rs_clear),  32'h0);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clock);
      rs_busy  = vecs[n].busy;
      rs_ready = vecs[n].ready;
      alloc_en = vecs[n].alloc;
      fu_stall = vecs[n].stall;
      flush    = vecs[n].flsh;
      #1;
      chk($sformatf("vec%0d_clear", n), 32'(rs_clear), 32'(vecs[n].clr));
      e.v = vecs[n].v; e.idx = vecs[n].idx; e.pkt = vecs[n].pkt; e.id = n;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL vec%0d_scoreboard: got empty queue want entry", n);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_valid", e.id),  32'(is_valid),  32'(e.v));
        chk($sformatf("vec%0d_idx", e.id),    32'(is_rs_idx), 32'(e.idx));
        chk($sformatf("vec%0d_packet", e.id), is_packet,      e.pkt);
      end
    end

    // Asynchronous reset while the issue register holds an instruction
    @(negedge clock);
    idle_inputs();
    rs_busy = 8'h01; rs_ready = 8'h01;
    @(posedge clock);
    #1;
    chk("pre_reset_valid", 32'(is_valid), 32'h1);
    #2;
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("async_reset_valid",  32'(is_valid), 32'h0);
    chk("async_reset_packet", is_packet,     32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_reset_clear", 32'(rs_clear), 32'h0);
    @(posedge clock);
    #1;
    chk("post_reset_valid", 32'(is_valid), 32'h0);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
- Issue-stage selector directly downstream of the reservation-station entries.
- Each cycle it picks one busy, ready RS entry, oldest first, and latches that entry's IS_PACKET into the IS/EX issue register that feeds the functional unit.
- It drives a one-hot clear back to the chosen entry, which frees the entry on the next edge.
- The IS/EX register stalls under FU back-pressure. A flush empties the register and the age state.

Parameters:
- RS_SIZE, 8: number of RS entries; must be >= 2.
- RS_IDX_W, $clog2(RS_SIZE): width of the issued entry index.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- rs_busy  in  RS_SIZE  busy flag from each RS entry.
- rs_ready  in  RS_SIZE  ready flag from each RS entry (both operands valid).
- rs_packets  in  RS_SIZE x IS_PACKET  entry_packet from each RS entry.
- alloc_en  in  RS_SIZE  one-hot or zero; the entry being written by dispatch this cycle.
- fu_stall  in  1  FU cannot accept a new instruction this cycle.
- flush  in  1  squash; synchronous, highest priority after reset.
- rs_clear  out  RS_SIZE  one-hot or zero, combinational; clears the issued entry.
- is_valid  out  1  issue register holds a valid instruction.
- is_packet  out  IS_PACKET  issue register contents.
- is_rs_idx  out  RS_IDX_W  entry index the issued instruction came from.

Behaviour:
- Reset (asynchronous): is_valid=0, is_packet='0, is_rs_idx=0, age matrix all 0. rs_clear depends only on inputs and is_valid, so it reads 0 while reset holds inputs idle.
- Eligibility: eligible[i] = rs_busy[i] & rs_ready[i] & ~alloc_en[i].
- Age matrix: older[i][j] for i != j.
  - When alloc_en[k] is high: row k is cleared, and column k is set (older[j][k]=1) for every j != k. The newly allocated entry is therefore younger than all others.
  - alloc_en with more than one bit set is illegal and need not be handled.
- Selection:
  - Entry i wins if eligible[i] and, for every eligible j != i, older[i][j] = 1.
  - If the matrix is inconsistent (e.g. straight after reset), the lowest-index eligible entry wins.
  - Exactly zero or one winner per cycle.
- Advance condition: advance = ~is_valid | ~fu_stall.
- rs_clear:
  - rs_clear = onehot(winner) when a winner exists, advance = 1 and flush = 0; otherwise 0.
  - The issued entry reads busy=0 on the cycle after the posedge.
- Issue register on posedge, in priority order:
  1. flush: is_valid <= 0 and the age matrix is cleared.
  2. advance with a winner: is_valid <= 1, is_packet <= rs_packets[winner], is_rs_idx <= winner.
  3. advance with no winner: is_valid <= 0; other fields hold.
  4. otherwise: hold all fields.
- Latency: an entry that becomes ready at edge N is issued at edge N+1, given no stall and no older eligible entry. Issue throughput is one instruction per cycle.
- Stall: while is_valid=1 and fu_stall=1, rs_clear=0 and the register holds. Ready entries stay in the RS.
- Simultaneous alloc and issue of different entries in one cycle: both take effect. The age update uses the pre-issue matrix; the issued entry's row and column become don't-care until it is reallocated.
- Flush with alloc in the same cycle: flush wins and the alloc's age update is dropped. Entry contents are the RS's responsibility.

Optional Feature:
- Macro: RS_ISSUE_AGE_SELECT_EN.
- Defined: oldest-first selection via the age matrix, as described above.
- Undefined: the age matrix is not built and alloc_en is ignored. The lowest-index eligible entry wins. All other behaviour is unchanged.

Test Plan:
- Reset mid-operation: assert reset while is_valid=1 -> is_valid=0 immediately (asynchronous); after release with all inputs idle, rs_clear=0.
- Age order: allocate entry 5, then entry 2, then entry 7 in successive cycles; set busy and ready on all three together -> issues idx 5, 2, 7 on three consecutive edges, each with its packet (inst 32'hABCDEF16, 32'hABCDEF13, 32'hABCDEF18). rs_clear is 8'h20, 8'h04, 8'h80 respectively. Without the macro the order is 2, 5, 7.
- Stall hold: entry 3 issued, then fu_stall=1 for 3 cycles while entry 4 is ready -> is_rs_idx stays 3, rs_clear=0; when the stall drops, entry 4 issues on the next edge.
- Ready late: entry 1 busy and not ready, entry 6 (younger) ready -> 6 issues first; then entry 1 becomes ready -> 1 issues on the following edge.
- Flush: is_valid=1, flush=1 together with alloc_en=8'h01 -> next cycle is_valid=0 and rs_clear=0; the age matrix is cleared.
- Empty: no eligible entries with fu_stall=0 -> is_valid falls to 0 and is_packet holds its last value.
